// File: rtl/des_ip_block_loader.sv
// Packs 8 UART bytes into a 64-bit DES block, applies IP (or FP when DES_IP_FP_EN is defined)
// and presents LEFT/RIGHT through a 1- or 2-slot valid/ready output buffer.
module des_ip_block_loader #(
    parameter bit MSB_FIRST   = 1'b1,
    parameter int OUT_DEPTH   = 1,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] LEFT,
    output logic [31:0] RIGHT,
    output logic        timeout
);

    if (OUT_DEPTH != 1 && OUT_DEPTH != 2) begin : g_bad_depth
        $error("des_ip_block_loader: OUT_DEPTH must be 1 or 2");
    end

    localparam int IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(TIMEOUT_CYC);

    // Entry n names the source bit for output bit n (vector index n is DES bit n).
    localparam int IP_TBL [1:64] = '{
        58, 50, 42, 34, 26, 18, 10,  2,
        60, 52, 44, 36, 28, 20, 12,  4,
        62, 54, 46, 38, 30, 22, 14,  6,
        64, 56, 48, 40, 32, 24, 16,  8,
        57, 49, 41, 33, 25, 17,  9,  1,
        59, 51, 43, 35, 27, 19, 11,  3,
        61, 53, 45, 37, 29, 21, 13,  5,
        63, 55, 47, 39, 31, 23, 15,  7
    };

    function automatic logic [64:1] permute_ip(input logic [64:1] blk);
        logic [64:1] res;
        for (int n = 1; n <= 64; n++) res[n] = blk[IP_TBL[n]];
        return res;
    endfunction

    logic [2:0]        cnt_q, cnt_d;
    logic [64:1]       coll_q, coll_d;
    logic [64:1]       blk_in, blk_perm, head;
    logic [64:1]       mem_q [OUT_DEPTH];
    logic              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]        occ_q, occ_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              timeout_q, timeout_d;
    logic              full, pop, push, accept;
    int                byte_lo;

    assign out_valid = (occ_q != 2'd0);

    // NOTE: combinational blocks use blocking '=' and give every output a default
    // first, so no path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        pop        = out_valid && out_ready;
        full       = (occ_q == 2'(OUT_DEPTH));
        byte_ready = !cs_n && (cnt_q != 3'd7 || !full || pop);
        accept     = byte_valid && byte_ready;
        push       = accept && (cnt_q == 3'd7);

        byte_lo = MSB_FIRST ? 57 - 8 * int'(cnt_q) : 1 + 8 * int'(cnt_q);
        blk_in  = coll_q;
        blk_in[byte_lo +: 8] = byte_in;

        cnt_d     = cnt_q;
        coll_d    = coll_q;
        idle_d    = idle_q;
        timeout_d = 1'b0;
        if (accept) begin
            cnt_d  = cnt_q + 3'd1;
            coll_d = push ? '0 : blk_in;
            idle_d = '0;
        end else if (TIMEOUT_CYC > 0 && cnt_q != 3'd0 && !(cnt_q == 3'd7 && full)) begin
            // A byte-7 stall on a full buffer is back-pressure, not an idle link.
            if (idle_q + IDLE_W'(1) == IDLE_LIM) begin
                cnt_d     = 3'd0;
                coll_d    = '0;
                idle_d    = '0;
                timeout_d = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end

        occ_d    = occ_q + {1'b0, push} - {1'b0, pop};
        wr_ptr_d = (push && OUT_DEPTH == 2) ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = (pop  && OUT_DEPTH == 2) ? ~rd_ptr_q : rd_ptr_q;
    end

`ifdef DES_IP_FP_EN
    localparam int FP_TBL [1:64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    function automatic logic [64:1] permute_fp(input logic [64:1] blk);
        logic [64:1] res;
        for (int n = 1; n <= 64; n++) res[n] = blk[FP_TBL[n]];
        return res;
    endfunction

    logic mode_q;

    always_ff @(posedge clk) begin
        if (!rst_n || cs_n) begin
            mode_q <= 1'b0;
        end else if (accept && cnt_q == 3'd0) begin
            mode_q <= mode;
        end
    end

    assign blk_perm = mode_q ? permute_fp(blk_in) : permute_ip(blk_in);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign blk_perm    = permute_ip(blk_in);
`endif

    // NOTE: state registers use non-blocking '<=' so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || cs_n) begin
            cnt_q     <= 3'd0;
            coll_q    <= '0;
            occ_q     <= 2'd0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            coll_q    <= coll_d;
            occ_q     <= occ_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
        end
    end

    // NOTE: buffer storage is not reset; occupancy alone decides validity and the
    // outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= blk_perm;
    end

    assign head    = mem_q[rd_ptr_q];
    assign LEFT    = out_valid ? head[64:33] : '0;
    assign RIGHT   = out_valid ? head[32:1]  : '0;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_des_ip_block_loader.sv
// Directed bench for des_ip_block_loader: instance A (MSB first, 1 slot, 16-cycle timeout)
// and instance B (LSB first, 2 slots, no timeout), checked against hand-derived IP/FP values.
module tb_des_ip_block_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cs_n, byte_valid, byte_ready, mode, out_valid, out_ready, timeout;
    logic [7:0]  byte_in;
    logic [31:0] left, right;

    logic        b_cs_n, b_byte_valid, b_byte_ready, b_mode, b_out_valid, b_out_ready, b_timeout;
    logic [7:0]  b_byte_in;
    logic [31:0] b_left, b_right;

    int n_checks = 0;
    int n_errors = 0;
    int to_pulses = 0;
    int pulses0;
    int cyc;
    logic [63:0] rnd, ipv;

    des_ip_block_loader #(.MSB_FIRST(1'b1), .OUT_DEPTH(1), .TIMEOUT_CYC(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .LEFT(left), .RIGHT(right), .timeout(timeout)
    );

    des_ip_block_loader #(.MSB_FIRST(1'b0), .OUT_DEPTH(2), .TIMEOUT_CYC(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .cs_n(b_cs_n), .byte_in(b_byte_in), .byte_valid(b_byte_valid),
        .byte_ready(b_byte_ready), .mode(b_mode), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .LEFT(b_left), .RIGHT(b_right), .timeout(b_timeout)
    );

    always @(negedge clk) if (timeout === 1'b1) to_pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic a_send(input logic [7:0] b);
        int guard;
        guard = 0;
        byte_in = b;
        byte_valid = 1'b1;
        @(negedge clk);
        while (byte_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("a_byte_ready", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic a_block(input logic [63:0] blk, input logic m0, input logic m1);
        for (int i = 0; i < 8; i++) begin
            mode = (i == 0) ? m0 : m1;
            a_send(blk[63-8*i -: 8]);
        end
        mode = 1'b0;
    endtask

    task automatic a_pop();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] b);
        int guard;
        guard = 0;
        b_byte_in = b;
        b_byte_valid = 1'b1;
        @(negedge clk);
        while (b_byte_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check("b_byte_ready", 64'(b_byte_ready), 64'd1);
        @(posedge clk);
        #1;
        b_byte_valid = 1'b0;
    endtask

    task automatic b_pop();
        b_out_ready = 1'b1;
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; cs_n = 1'b0; byte_in = '0; byte_valid = 1'b0; mode = 1'b0; out_ready = 1'b0;
        b_cs_n = 1'b0; b_byte_in = '0; b_byte_valid = 1'b0; b_mode = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_left", 64'(left), 64'd0);
        check("rst_right", 64'(right), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_byte_ready", 64'(byte_ready), 64'd1);

        // IP(00..00 01): in[1] -> out[40] = LEFT bit 7
        a_block(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        check("ip1_valid", 64'(out_valid), 64'd1);
        check("ip1_left", 64'(left), 64'h80);
        check("ip1_right", 64'(right), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("ip1_hold_valid", 64'(out_valid), 64'd1);
        check("ip1_hold_left", 64'(left), 64'h80);
        a_pop();
        check("pop_empty_valid", 64'(out_valid), 64'd0);
        check("pop_empty_left", 64'(left), 64'd0);

        // in[64] -> out[25] = RIGHT bit 24
        a_block(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        check("ip64_left", 64'(left), 64'd0);
        check("ip64_right", 64'(right), 64'h0100_0000);
        a_pop();
        // in[49] -> out[34] = LEFT bit 1
        a_block(64'h0001_0000_0000_0000, 1'b0, 1'b0);
        check("ip49_left", 64'(left), 64'h2);
        check("ip49_right", 64'(right), 64'd0);
        a_pop();
        a_block(64'h8000_0000_0000_0001, 1'b0, 1'b0);
        check("ip_mix_left", 64'(left), 64'h80);
        check("ip_mix_right", 64'(right), 64'h0100_0000);
        a_pop();

`ifdef DES_IP_FP_EN
        // FP: in[1] -> out[58] = LEFT bit 25
        a_block(64'h0000_0000_0000_0001, 1'b1, 1'b1);
        check("fp1_left", 64'(left), 64'h0200_0000);
        check("fp1_right", 64'(right), 64'd0);
        a_pop();
        a_block(64'h0000_0000_0000_0001, 1'b1, 1'b0);
        check("fp_latch_left", 64'(left), 64'h0200_0000);
        a_pop();
        a_block(64'h0000_0000_0000_0001, 1'b0, 1'b1);
        check("ip_latch_left", 64'(left), 64'h80);
        a_pop();
        rnd = {$urandom, $urandom};
        a_block(rnd, 1'b0, 1'b0);
        ipv = {left, right};
        a_pop();
        a_block(ipv, 1'b1, 1'b1);
        check("fp_roundtrip", {left, right}, rnd);
        a_pop();
`else
        a_block(64'h0000_0000_0000_0001, 1'b1, 1'b1);
        check("mode_ignored_left", 64'(left), 64'h80);
        a_pop();
`endif

        // Byte 7 stalls on a full single slot; pop and push share one edge.
        a_block(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        a_send(8'h80);
        for (int i = 1; i < 7; i++) a_send(8'h00);
        byte_in = 8'h00;
        byte_valid = 1'b1;
        pulses0 = to_pulses;
        repeat (20) @(negedge clk);
        check("stall_ready", 64'(byte_ready), 64'd0);
        check("stall_head_left", 64'(left), 64'h80);
        check("stall_no_timeout", 64'(to_pulses - pulses0), 64'd0);
        out_ready = 1'b1;
        #1;
        check("popush_ready", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        out_ready = 1'b0;
        check("popush_valid", 64'(out_valid), 64'd1);
        check("popush_left", 64'(left), 64'd0);
        check("popush_right", 64'(right), 64'h0100_0000);
        a_pop();
        check("popush_drained", 64'(out_valid), 64'd0);

        // Partial block of 3 bytes times out 16 idle cycles later.
        pulses0 = to_pulses;
        a_send(8'hAA);
        a_send(8'hBB);
        a_send(8'hCC);
        cyc = 0;
        while (timeout !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("to_latency", 64'(cyc), 64'd16);
        check("to_no_valid", 64'(out_valid), 64'd0);
        a_block(64'h0001_0000_0000_0000, 1'b0, 1'b0);
        check("to_after_left", 64'(left), 64'h2);
        check("to_after_right", 64'(right), 64'd0);
        check("to_single_pulse", 64'(to_pulses - pulses0), 64'd1);
        a_pop();

        // cs_n flush with one block buffered and 5 bytes collected.
        a_block(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        repeat (5) a_send(8'h11);
        cs_n = 1'b1;
        @(posedge clk);
        #1;
        check("cs_valid", 64'(out_valid), 64'd0);
        check("cs_left", 64'(left), 64'd0);
        check("cs_right", 64'(right), 64'd0);
        check("cs_byte_ready", 64'(byte_ready), 64'd0);
        cs_n = 1'b0;
        a_block(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        check("cs_ff_left", 64'(left), 64'hFFFF_FFFF);
        check("cs_ff_right", 64'(right), 64'hFFFF_FFFF);
        a_pop();

        // rst_n flush, then a pattern that exposes a stale byte count.
        a_block(64'h8000_0000_0000_0000, 1'b0, 1'b0);
        repeat (5) a_send(8'h11);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst2_valid", 64'(out_valid), 64'd0);
        check("rst2_left", 64'(left), 64'd0);
        check("rst2_right", 64'(right), 64'd0);
        rst_n = 1'b1;
        a_block(64'h0000_0000_0000_0001, 1'b0, 1'b0);
        check("rst2_new_left", 64'(left), 64'h80);
        check("rst2_new_right", 64'(right), 64'd0);
        a_pop();

        // Instance B: LSB-first packing, two slots, FIFO order through a full push+pop.
        b_send(8'h01);
        repeat (7) b_send(8'h00);
        check("b_x_valid", 64'(b_out_valid), 64'd1);
        check("b_x_left", 64'(b_left), 64'h80);
        b_send(8'h02);
        repeat (7) b_send(8'h00);
        check("b_head_still_x", 64'(b_left), 64'h80);
        b_send(8'h04);
        repeat (6) b_send(8'h00);
        b_byte_in = 8'h00;
        b_byte_valid = 1'b1;
        @(negedge clk);
        check("b_full_stall", 64'(b_byte_ready), 64'd0);
        b_out_ready = 1'b1;
        #1;
        check("b_popush_ready", 64'(b_byte_ready), 64'd1);
        @(posedge clk);
        #1;
        b_byte_valid = 1'b0;
        b_out_ready = 1'b0;
        check("b_y_valid", 64'(b_out_valid), 64'd1);
        check("b_y_left", 64'(b_left), 64'd0);
        check("b_y_right", 64'(b_right), 64'h80);
        b_pop();
        check("b_z_left", 64'(b_left), 64'h8000);
        check("b_z_right", 64'(b_right), 64'd0);
        b_pop();
        check("b_empty_valid", 64'(b_out_valid), 64'd0);
        check("b_empty_left", 64'(b_left), 64'd0);
        check("b_no_timeout", 64'(b_timeout), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
